// File: rtl/execute_control_pkg.sv
// Shared definitions for the execute_control issue/writeback stage:
// datapath sizes, ALU opcode encodings, instruction layout and FSM states.
package execute_control_pkg;

  localparam int unsigned DEF_WORD_SIZE = 16;
  localparam int unsigned REG_COUNT     = 8;
  localparam int unsigned REG_AW        = 3;
  localparam int unsigned INSTR_WIDTH   = 16;
  localparam int unsigned OPC_W         = 5;
  localparam int unsigned IMM_W         = 5;

  // ALU opcode encodings (must match the ALU)
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd0;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd1;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'd2;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd3;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd4;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd5;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd6;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd7;
  localparam logic [OPC_W-1:0] OP_COMP = 5'd8;
  localparam logic [OPC_W-1:0] OP_SRI  = 5'd9;
  localparam logic [OPC_W-1:0] OP_SLI  = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Instruction layout: [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2.
  // I-type immediate is {rs2, lo} = [4:0].
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [1:0]        lo;
  } instr_t;

  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    case (op)
      OP_NOT, OP_AND, OP_ANDI, OP_OR, OP_XOR, OP_ADD,
      OP_ADDI, OP_SUB, OP_COMP, OP_SRI, OP_SLI: is_legal = 1'b1;
      default:                                  is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_zext_imm(input logic [OPC_W-1:0] op);
    case (op)
      OP_ANDI, OP_SRI, OP_SLI: is_zext_imm = 1'b1;
      default:                 is_zext_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_control_register_file.sv
// 8-entry register file with r0 hardwired to zero.
// Ports: two combinational operand reads, one combinational debug read,
// one synchronous write port; async active-low reset clears all entries.
module execute_control_register_file
  import execute_control_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [REG_AW-1:0]    i_rd_addr1,
  output logic [WORD_SIZE-1:0] o_rd_data1,
  input  logic [REG_AW-1:0]    i_rd_addr2,
  output logic [WORD_SIZE-1:0] o_rd_data2,
  input  logic [REG_AW-1:0]    i_dbg_addr,
  output logic [WORD_SIZE-1:0] o_dbg_data,
  input  logic                 i_wr_en,
  input  logic [REG_AW-1:0]    i_wr_addr,
  input  logic [WORD_SIZE-1:0] i_wr_data
);

  logic [WORD_SIZE-1:0] r_regs [REG_COUNT];

  // Write port; writes to r0 are dropped
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(REG_COUNT); i++) r_regs[i] <= '0;
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data1 = (i_rd_addr1 == '0) ? '0 : r_regs[i_rd_addr1];
  assign o_rd_data2 = (i_rd_addr2 == '0) ? '0 : r_regs[i_rd_addr2];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/execute_control.sv
// Multi-cycle issue/writeback stage in front of the ALU.
// Ports: instr_valid/instr/instr_ready handshake; alu_opcode/alu_input1/
// alu_input2/alu_enable to the ALU and alu_out back; wb_valid/wb_addr/
// wb_data writeback pulse; illegal pulse; dbg_addr/dbg_data regfile peek.
module execute_control
  import execute_control_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_ready,
  output logic [OPC_W-1:0]       alu_opcode,
  output logic [WORD_SIZE-1:0]   alu_input1,
  output logic [WORD_SIZE-1:0]   alu_input2,
  output logic                   alu_enable,
  input  logic [WORD_SIZE-1:0]   alu_out,
  output logic                   wb_valid,
  output logic [REG_AW-1:0]      wb_addr,
  output logic [WORD_SIZE-1:0]   wb_data,
  output logic                   illegal,
  input  logic [REG_AW-1:0]      dbg_addr,
  output logic [WORD_SIZE-1:0]   dbg_data
);

  state_t               r_state;
  instr_t               r_instr;
  logic                 r_instr_ready;
  logic [OPC_W-1:0]     r_alu_opcode;
  logic [WORD_SIZE-1:0] r_alu_input1;
  logic [WORD_SIZE-1:0] r_alu_input2;
  logic                 r_alu_enable;
  logic                 r_wb_valid;
  logic [REG_AW-1:0]    r_wb_addr;
  logic                 r_illegal;

  logic [WORD_SIZE-1:0] w_rs1_data;
  logic [WORD_SIZE-1:0] w_rs2_data;
  logic [WORD_SIZE-1:0] w_op2;
  logic [IMM_W-1:0]     w_imm5;
  logic                 w_wr_en;

  assign w_imm5  = {r_instr.rs2, r_instr.lo};
  assign w_wr_en = (r_state == ST_WB);

  execute_control_register_file #(
    .WORD_SIZE (WORD_SIZE)
  ) u_regfile (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_rd_addr1 (r_instr.rs1),
    .o_rd_data1 (w_rs1_data),
    .i_rd_addr2 (r_instr.rs2),
    .o_rd_data2 (w_rs2_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (r_instr.rd),
    .i_wr_data  (alu_out)
  );

  // Second operand: register, extended immediate, or zero for NOT
  always_comb begin
    w_op2 = w_rs2_data;
    if (r_instr.opcode == OP_NOT) begin
      w_op2 = '0;
    end else if (r_instr.opcode == OP_ADDI) begin
      w_op2 = WORD_SIZE'($signed(w_imm5));
    end else if (is_zext_imm(r_instr.opcode)) begin
      w_op2 = WORD_SIZE'(w_imm5);
    end
  end

  // Control FSM; strobes default low and are raised for one cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_instr       <= '0;
      r_instr_ready <= 1'b1;
      r_alu_opcode  <= '0;
      r_alu_input1  <= '0;
      r_alu_input2  <= '0;
      r_alu_enable  <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_addr     <= '0;
      r_illegal     <= 1'b0;
    end else begin
      r_alu_enable <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_illegal    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_instr       <= instr_t'(instr);
            r_instr_ready <= 1'b0;
            r_state       <= ST_READ;
          end
        end
        ST_READ: begin
          if (is_legal(r_instr.opcode)) begin
            r_alu_opcode <= r_instr.opcode;
            r_alu_input1 <= w_rs1_data;
            r_alu_input2 <= w_op2;
            r_alu_enable <= 1'b1;
            r_state      <= ST_EXEC;
          end else begin
            r_illegal     <= 1'b1;
            r_instr_ready <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_wb_valid <= 1'b1;
          r_wb_addr  <= r_instr.rd;
          r_state    <= ST_WB;
        end
        ST_WB: begin
          r_instr_ready <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = r_instr_ready;
  assign alu_opcode  = r_alu_opcode;
  assign alu_input1  = r_alu_input1;
  assign alu_input2  = r_alu_input2;
  assign alu_enable  = r_alu_enable;
  assign wb_valid    = r_wb_valid;
  assign wb_addr     = r_wb_addr;
  assign illegal     = r_illegal;
  // The ALU result only arrives at the start of WB, so pass it straight through
  assign wb_data     = w_wr_en ? alu_out : '0;

endmodule

// File: doc/execute_control.md
Name: execute_control

Overview:
- Multi-cycle issue/writeback stage sitting directly upstream of the ALU.
- Accepts one 16-bit instruction per valid/ready handshake and decodes opcode, register and immediate fields.
- Reads operands from an internal 8-entry register file and drives the ALU's opcode, input1, input2 and alu_enable.
- Captures the ALU's registered result one cycle later and writes it back to the register file.

Parameters:
- WORD_SIZE, default from parameters.vh (16 in bench), datapath width; matches the ALU.
- REG_COUNT, 8, number of architectural registers; index width is 3.
- INSTR_WIDTH, 16, instruction word width.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  upstream presents an instruction.
- instr  in  16  instruction word.
- instr_ready  out  1  stage can accept an instruction; high only in IDLE.
- alu_opcode  out  5  opcode to the ALU.
- alu_input1  out  WORD_SIZE  first ALU operand (rs1).
- alu_input2  out  WORD_SIZE  second ALU operand (rs2 or extended immediate).
- alu_enable  out  1  ALU capture strobe.
- alu_out  in  WORD_SIZE  registered ALU result.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_addr  out  3  destination register index.
- wb_data  out  WORD_SIZE  written value.
- illegal  out  1  one-cycle pulse for an unsupported opcode.
- dbg_addr  in  3  debug register-file read index.
- dbg_data  out  WORD_SIZE  combinational register-file read (r0 reads 0).

Behaviour:
- Instruction encoding:
  - [15:11] opcode; [10:8] rd; [7:5] rs1; [4:2] rs2 (R-type).
  - [4:0] imm5 (I-type: ADDI, ANDI, SRI, SLI).
- Immediate extension: ADDI sign-extends imm5 to WORD_SIZE; ANDI, SRI and SLI zero-extend it.
- NOT drives alu_input2 = 0.
- r0 is hardwired to zero: reads return 0 and writes are dropped, but wb_valid still pulses with wb_addr=0.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid=1 at a rising edge, latch instr and go to READ. Otherwise stay in IDLE.
  - READ: decode the latched instruction.
    - Legal opcode (NOT, AND, ANDI, OR, XOR, ADD, ADDI, SUB, COMP, SRI, SLI): register alu_opcode, alu_input1 and alu_input2 from the regfile/immediate, then go to EXEC.
    - Any other opcode: pulse illegal for the next cycle, return to IDLE, no ALU activity, no write.
  - EXEC: alu_enable=1 for exactly this one cycle; the ALU samples at the closing edge. Go to WB.
  - WB:
    - Write alu_out into rd; go to IDLE.
    - wb_valid=1, wb_addr=rd, wb_data=alu_out during this cycle.
- Latency: handshake edge -> WB cycle is 3 cycles; throughput is 1 instruction per 4 cycles.
- Legal instructions always write rd; COMP writes 1 or 0.
- ALU operand outputs hold their values outside EXEC; only alu_enable gates the ALU.
- A new handshake is impossible while not in IDLE, because instr_ready=0.
- Operand reads in READ observe all prior writebacks. No hazards exist because only one instruction is in flight at a time.
- Reset (asynchronous assert, any state, including mid-EXEC or mid-WB):
  - state=IDLE; all registers = 0.
  - alu_opcode=0, alu_input1=0, alu_input2=0, alu_enable=0.
  - wb_valid=0, wb_addr=0, wb_data=0, illegal=0.
  - instr_ready=1 after release.
  - A stale alu_out after reset is never written, because WB is reachable only via EXEC.
- Release of reset_n is synchronised externally; the first accept is allowed on the first edge after release.

Decomposition:
- Opcode defines (`NOT ... `SLI) and WORD_SIZE stay in the shared parameters.vh.
- Add to parameters.vh:
  - instruction field positions;
  - FSM state encodings (IDLE=0, READ=1, EXEC=2, WB=3);
  - REG_COUNT.
- Sub-module register_file: 2 combinational read ports plus 1 debug read port, 1 synchronous write port, r0 forced to 0, async active-low reset.

Test Plan:
- Reset mid-EXEC: assert reset_n=0 during EXEC -> alu_enable=0 immediately; no wb_valid ever; instr_ready=1 after release; dbg_data=0 for all registers.
- ADDI then ADD:
  - ADDI r1,r0,-3 -> wb_data=0xFFFD.
  - ADDI r2,r0,5 -> wb_data=5.
  - ADD r3,r1,r2 -> wb_valid in the 3rd cycle after the handshake with wb_addr=3, wb_data=0x0002.
  - alu_enable high exactly one cycle per instruction.
- ANDI zero-extend: r1=0xFFFD, ANDI r4,r1,0x1F -> wb_data=0x001D.
- Shifts and compare:
  - SLI r5,r2,3 -> 0x0028.
  - SRI r6,r5,2 -> 0x000A.
  - COMP r7,r2,r2 -> 1.
  - COMP r7,r1,r2 -> 0.
- Illegal and r0:
  - Opcode 5'h1F -> illegal pulse; no wb_valid; return to IDLE.
  - ADDI r0,r0,7 -> wb_valid=1 with wb_addr=0; dbg_data(0)=0.
- Back-to-back: hold instr_valid=1 continuously -> instr_ready high once every 4 cycles; instructions are accepted in order and each is written before the next READ.
